// File: rtl/pb_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the default stability window.
package pb_pkg;

   typedef enum logic [1:0] {
      ST_LOW       = 2'b00,
      ST_WAIT_HIGH = 2'b01,
      ST_HIGH      = 2'b10,
      ST_WAIT_LOW  = 2'b11
   } pb_state_e;

   localparam int unsigned STABLE_CYCLES_DEF = 16;

endpackage

// File: rtl/pb_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; reusable for any
// pin that crosses into the clk domain.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/pb_debouncer.sv
// Push-button debouncer: synchronizes the raw pin, then accepts a level change
// only after it has held for STABLE_CYCLES cycles, emitting press/release pulses.
module pb_debouncer
   import pb_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned CNT_W         = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pbRaw,
   output logic pbClean,
   output logic pressPulse,
   output logic releasePulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             pb_sync;
   pb_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean_q, clean_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   sync_2ff u_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (pbRaw),
      .q_o   (pb_sync)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_LOW;
         cnt_q     <= '0;
         clean_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clean_q   <= clean_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clean_d   = clean_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
         ST_LOW: begin
            clean_d = 1'b0;
            if (pb_sync) begin
               state_d = ST_WAIT_HIGH;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         ST_WAIT_HIGH: begin
            if (!pb_sync) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               clean_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            clean_d = 1'b1;
            if (!pb_sync) begin
               state_d = ST_WAIT_LOW;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         ST_WAIT_LOW: begin
            if (pb_sync) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_LOW;
               cnt_d     = '0;
               clean_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            clean_d = 1'b0;
         end
      endcase
   end

   assign pbClean      = clean_q;
   assign pressPulse   = press_q;
   assign releasePulse = release_q;

endmodule

// File: tb/tb_pb_debouncer.sv
// Directed bench for pb_debouncer: a STABLE_CYCLES=4 instance and a default
// instance, driven and sampled 1 time unit after each rising edge.
module tb_pb_debouncer;
   import pb_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic raw4  = 1'b0;
   logic raw16 = 1'b0;
   logic clean4, press4, rel4;
   logic clean16, press16, rel16;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned press4_n  = 0;
   int unsigned rel4_n    = 0;
   int unsigned press16_n = 0;
   int unsigned p_base, r_base;
   logic        seen;

   always #5 clk = ~clk;

   pb_debouncer #(.STABLE_CYCLES(4), .CNT_W(16)) dut4 (
      .clk          (clk),
      .reset        (reset),
      .pbRaw        (raw4),
      .pbClean      (clean4),
      .pressPulse   (press4),
      .releasePulse (rel4)
   );

   pb_debouncer #(.STABLE_CYCLES(16), .CNT_W(16)) dut16 (
      .clk          (clk),
      .reset        (reset),
      .pbRaw        (raw16),
      .pbClean      (clean16),
      .pressPulse   (press16),
      .releasePulse (rel16)
   );

   always @(negedge clk) begin
      if (press4)  press4_n  <= press4_n + 1;
      if (rel4)    rel4_n    <= rel4_n + 1;
      if (press16) press16_n <= press16_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance n cycles while remembering whether pbClean of dut4 ever went high.
   task automatic drive4(input logic v, input int unsigned n);
      raw4 = v;
      for (int unsigned i = 0; i < n; i++) begin
         tick(1);
         seen = seen | clean4;
      end
   endtask

   task automatic drive16(input logic v, input int unsigned n);
      raw16 = v;
      for (int unsigned i = 0; i < n; i++) begin
         tick(1);
         seen = seen | clean16;
      end
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("rst_clean", 32'(clean4), 32'd0);
      chk("rst_press", 32'(press4), 32'd0);
      chk("rst_rel",   32'(rel4),   32'd0);
      chk("rst_state", 32'(dut4.state_q), 32'(ST_LOW));
      chk("rst_clean16", 32'(clean16), 32'd0);
      reset = 1'b0;
      tick(2);

      // Clean press: rise at E5
      p_base = press4_n; r_base = rel4_n;
      raw4 = 1'b1;
      tick(5);
      chk("press_E4_clean", 32'(clean4), 32'd0);
      tick(1);
      chk("press_E5_clean", 32'(clean4), 32'd1);
      chk("press_E5_pulse", 32'(press4), 32'd1);
      chk("press_E5_rel",   32'(rel4),   32'd0);
      tick(1);
      chk("press_E6_pulse", 32'(press4), 32'd0);
      chk("press_E6_clean", 32'(clean4), 32'd1);
      tick(3);
      chk("press_count", press4_n - p_base, 32'd1);
      chk("press_relcount", rel4_n - r_base, 32'd0);

      // Release: fall at E5
      p_base = press4_n; r_base = rel4_n;
      raw4 = 1'b0;
      tick(5);
      chk("rel_E4_clean", 32'(clean4), 32'd1);
      tick(1);
      chk("rel_E5_clean", 32'(clean4), 32'd0);
      chk("rel_E5_pulse", 32'(rel4),   32'd1);
      chk("rel_E5_press", 32'(press4), 32'd0);
      tick(3);
      chk("rel_count",      rel4_n - r_base,   32'd1);
      chk("rel_presscount", press4_n - p_base, 32'd0);

      // Bounce rejection: 3 high, 1 low, 2 high, low
      p_base = press4_n; seen = 1'b0;
      drive4(1'b1, 3);
      drive4(1'b0, 1);
      drive4(1'b1, 2);
      drive4(1'b0, 8);
      chk("bounce_clean", 32'(seen), 32'd0);
      chk("bounce_press", press4_n - p_base, 32'd0);
      chk("bounce_state", 32'(dut4.state_q), 32'(ST_LOW));

      // Bouncy press then stable: timed from the last 0->1 sample
      p_base = press4_n;
      drive4(1'b1, 2);
      drive4(1'b0, 1);
      drive4(1'b1, 3);
      drive4(1'b0, 1);
      raw4 = 1'b1;
      tick(5);
      chk("bouncy_E4_clean", 32'(clean4), 32'd0);
      tick(1);
      chk("bouncy_E5_clean", 32'(clean4), 32'd1);
      chk("bouncy_E5_pulse", 32'(press4), 32'd1);
      tick(4);
      chk("bouncy_count", press4_n - p_base, 32'd1);
      raw4 = 1'b0;
      tick(10);

      // Reset mid-count with cnt=2 in ST_WAIT_HIGH
      raw4 = 1'b1;
      tick(4);
      chk("mid_state", 32'(dut4.state_q), 32'(ST_WAIT_HIGH));
      chk("mid_cnt",   32'(dut4.cnt_q),   32'd2);
      reset = 1'b1;
      tick(1);
      chk("mid_rst_clean", 32'(clean4), 32'd0);
      chk("mid_rst_press", 32'(press4), 32'd0);
      chk("mid_rst_rel",   32'(rel4),   32'd0);
      chk("mid_rst_state", 32'(dut4.state_q), 32'(ST_LOW));
      p_base = press4_n;
      reset = 1'b0;
      tick(5);
      chk("mid_E4_clean", 32'(clean4), 32'd0);
      tick(1);
      chk("mid_E5_clean", 32'(clean4), 32'd1);
      chk("mid_E5_pulse", 32'(press4), 32'd1);
      tick(3);
      chk("mid_count", press4_n - p_base, 32'd1);
      raw4 = 1'b0;
      tick(10);

      // Default window: hold 20 cycles -> rise at E17
      p_base = press16_n;
      raw16 = 1'b1;
      tick(17);
      chk("def_E16_clean", 32'(clean16), 32'd0);
      tick(1);
      chk("def_E17_clean", 32'(clean16), 32'd1);
      chk("def_E17_pulse", 32'(press16), 32'd1);
      tick(2);
      raw16 = 1'b0;
      tick(20);
      chk("def_release_clean", 32'(clean16), 32'd0);
      chk("def_count", press16_n - p_base, 32'd1);

      // 15-cycle pulse is rejected by the default window
      p_base = press16_n; seen = 1'b0;
      drive16(1'b1, 15);
      drive16(1'b0, 20);
      chk("def15_clean", 32'(seen), 32'd0);
      chk("def15_press", press16_n - p_base, 32'd0);
      chk("def15_state", 32'(dut16.state_q), 32'(ST_LOW));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
